// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the status-LED event sequencer:
//   - event-type encodings carried on ev_type
//   - sequencer FSM state encodings
//   - number of physical units that can raise an event
//   - packed FIFO record layout and small decode helpers
// ---------------------------------------------------------------------------
package led_pkg;

  // Event-type encodings; EV_NONE marks an empty/invalid record
  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_IFAULT = 2'd1,
    EV_PBLOCK = 2'd2,
    EV_BDROP  = 2'd3
  } ev_type_t;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Units 0..UNIT_COUNT-1 are real; index 3 is reserved as invalid
  localparam int UNIT_COUNT = 3;

  // One FIFO entry: unit index plus event type
  typedef struct packed {
    logic [1:0] unit;
    ev_type_t   ev_type;
  } ev_rec_t;

  localparam int REC_W = $bits(ev_rec_t);

  // A record is worth showing only if it names a real unit and a real event
  function automatic logic rec_is_valid(input logic [1:0] unit, input logic [1:0] ev_type);
    return (int'(unit) < UNIT_COUNT) && (ev_type != EV_NONE);
  endfunction

  // Flag vector ordered {i_fault, p_block, b_drop}; at most one bit set
  function automatic logic [2:0] flags_for(input ev_type_t ev_type);
    case (ev_type)
      EV_IFAULT: return 3'b100;
      EV_PBLOCK: return 3'b010;
      EV_BDROP:  return 3'b001;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/led_event_sequencer_if.sv
// ---------------------------------------------------------------------------
// led_event_sequencer_if
// Valid/ready event channel from the navigation / pick-and-place FSMs to the
// LED event sequencer.
//   ev_valid  producer -> sequencer  record valid
//   ev_ready  sequencer -> producer  record can be taken this cycle
//   ev_unit   producer -> sequencer  unit index (0..2 valid, 3 invalid)
//   ev_type   producer -> sequencer  event type (0 = none / invalid)
// master = producer side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface led_event_sequencer_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_unit;
  logic [1:0] ev_type;

  modport master (output ev_valid, output ev_unit, output ev_type, input ev_ready);
  modport slave  (input ev_valid, input ev_unit, input ev_type, output ev_ready);
endinterface

// File: rtl/event_fifo.sv
// ---------------------------------------------------------------------------
// event_fifo
// Small synchronous FIFO with registered storage and no write-to-read bypass.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate occupancy counter.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   push, din   write request and data (ignored while full)
//   pop, dout   read request (ignored while empty) and head-of-queue data
//   full, empty occupancy flags, derived from the pointers only
// ---------------------------------------------------------------------------
module event_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full when the index bits match but the wrap bits differ
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Storage needs no reset; the pointers decide what is valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer advance; reset empties the queue by realigning both pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/led_event_sequencer.sv
// ---------------------------------------------------------------------------
// led_event_sequencer
// Queues (unit, event) records and replays them to the LED driver one at a
// time: each event's flag is held for HOLD_CYCLES, then all flags stay low
// for GAP_CYCLES so consecutive indications remain distinguishable.
// Ports:
//   clk_50M    system clock (rising edge)
//   reset      synchronous, active-high
//   ev         event channel (slave side of led_event_sequencer_if)
//   unitlist   unit of the event being shown, kept after the flag drops
//   i_fault, p_block, b_drop  one-hot event flags
//   busy       sequencer active or records still queued
//   err_count  invalid records discarded, saturating at 255
// ---------------------------------------------------------------------------
module led_event_sequencer
  import led_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                 clk_50M,
  input  logic                 reset,
  led_event_sequencer_if.slave ev,
  output logic [1:0]           unitlist,
  output logic                 i_fault,
  output logic                 p_block,
  output logic                 b_drop,
  output logic                 busy,
  output logic [7:0]           err_count
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       flags_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             rec_ok;
  logic             push;
  logic             pop;
  ev_rec_t          in_rec;
  ev_rec_t          head;
  logic [REC_W-1:0] head_bits;

  // Ready depends only on fill level, so a pop from full frees a slot
  // for the following cycle rather than the current one
  assign ev.ev_ready = !fifo_full;
  assign accept      = ev.ev_valid && !fifo_full;
  assign rec_ok      = rec_is_valid(ev.ev_unit, ev.ev_type);
  assign push        = accept && rec_ok;
  assign pop         = (state == ST_IDLE) && !fifo_empty;
  assign in_rec      = '{unit: ev.ev_unit, ev_type: ev_type_t'(ev.ev_type)};
  assign head        = ev_rec_t'(head_bits);

  assign {i_fault, p_block, b_drop} = flags_q;
  assign busy = (state != ST_IDLE) || !fifo_empty;

  event_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_50M),
    .reset (reset),
    .push  (push),
    .din   (in_rec),
    .pop   (pop),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Show/gap sequencer. unitlist is only rewritten on a pop, so it holds the
  // last unit through GAP and IDLE; the LED driver relies on all-flags-low
  // rather than on unitlist to stop the indication.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      unitlist <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            unitlist <= head.unit;
            flags_q  <= flags_for(head.ev_type);
            cnt      <= HOLD_LOAD;
            state    <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (cnt == '0) begin
            flags_q <= '0;
            cnt     <= GAP_LOAD;
            state   <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          flags_q <= '0;
        end
      endcase
    end
  end

  // Invalid records still complete the handshake; they are only counted
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      err_count <= '0;
    end else if (accept && !rec_ok && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule
